aura_mixer: RTL and testbench



---
 rtl/aura_pkg.sv | 30 +++
 rtl/aura_sat16.sv | 30 +++
 rtl/aura_mixer.sv | 216 +++++++++++++++++++++
 tb/tb_aura_mixer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aura_pkg.sv
// Shared constants for the AURA stereo mixer: register map, CTRL bit positions,
// default gains and the sample snapshot taken on each output tick.
package aura_pkg;

   localparam int SAMPLE_W = 16;
   localparam int GAIN_W   = 8;

   localparam int AURA_GAIN_FRAC_DEF = 7;

   localparam logic [1:0] AURA_MIX_OPM_GAIN = 2'd0;
   localparam logic [1:0] AURA_MIX_VA_GAIN  = 2'd1;
   localparam logic [1:0] AURA_MIX_MST_GAIN = 2'd2;
   localparam logic [1:0] AURA_MIX_CTRL     = 2'd3;

   localparam int CTRL_MUTE_BIT = 0;
   localparam int CTRL_OVR_BIT  = 6;
   localparam int CTRL_CLIP_BIT = 7;

   localparam logic [GAIN_W-1:0] AURA_OPM_GAIN_DEF = 8'h40;
   localparam logic [GAIN_W-1:0] AURA_VA_GAIN_DEF  = 8'h40;
   localparam logic [GAIN_W-1:0] AURA_MST_GAIN_DEF = 8'h80;

   typedef struct packed {
      logic [SAMPLE_W-1:0] opm_l;
      logic [SAMPLE_W-1:0] opm_r;
      logic [SAMPLE_W-1:0] va_l;
      logic [SAMPLE_W-1:0] va_r;
   } aura_snap_t;

endpackage

// File: rtl/aura_sat16.sv
// Arithmetic (floor) right shift of a signed value followed by a clamp to
// 16-bit signed; clip_o flags that the clamp was applied.
module aura_sat16 #(
   parameter int IN_W  = 26,
   parameter int SHIFT = 7
) (
   input  logic [IN_W-1:0] din_i,
   output logic [15:0]     dout_o,
   output logic            clip_o
);

   localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'(32767);
   localparam logic signed [IN_W-1:0] SAT_MIN = ~SAT_MAX;

   logic signed [IN_W-1:0] shifted;

   always_comb begin
      shifted = $signed(din_i) >>> SHIFT;
      dout_o  = shifted[15:0];
      clip_o  = 1'b0;
      if (shifted > SAT_MAX) begin
         dout_o = 16'h7FFF;
         clip_o = 1'b1;
      end else if (shifted < SAT_MIN) begin
         dout_o = 16'h8000;
         clip_o = 1'b1;
      end
   end

endmodule

// File: rtl/aura_mixer.sv
// Programmable stereo mixer: per-source and master gains applied with a single
// time-multiplexed 16x9 multiplier, one output sample per sample_tick.
module aura_mixer
   import aura_pkg::*;
#(
   parameter int                GAIN_FRAC    = AURA_GAIN_FRAC_DEF,
   parameter logic [GAIN_W-1:0] OPM_GAIN_RST = AURA_OPM_GAIN_DEF,
   parameter logic [GAIN_W-1:0] VA_GAIN_RST  = AURA_VA_GAIN_DEF,
   parameter logic [GAIN_W-1:0] MST_GAIN_RST = AURA_MST_GAIN_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                sample_tick,
   input  logic [SAMPLE_W-1:0] opm_l_i,
   input  logic [SAMPLE_W-1:0] opm_r_i,
   input  logic [SAMPLE_W-1:0] va_l_i,
   input  logic [SAMPLE_W-1:0] va_r_i,
   input  logic                reg_wr,
   input  logic [1:0]          reg_addr,
   input  logic [GAIN_W-1:0]   reg_wdata,
   output logic [GAIN_W-1:0]   reg_rdata,
   output logic [SAMPLE_W-1:0] l_chan_o,
   output logic [SAMPLE_W-1:0] r_chan_o,
   output logic                out_valid
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ML0  = 3'd1;
   localparam logic [2:0] S_ML1  = 3'd2;
   localparam logic [2:0] S_MSL  = 3'd3;
   localparam logic [2:0] S_MR0  = 3'd4;
   localparam logic [2:0] S_MR1  = 3'd5;
   localparam logic [2:0] S_MSR  = 3'd6;

   logic [2:0]          state_q, state_d;
   logic [GAIN_W-1:0]   opm_gain_q, opm_gain_d;
   logic [GAIN_W-1:0]   va_gain_q, va_gain_d;
   logic [GAIN_W-1:0]   mst_gain_q, mst_gain_d;
   logic                mute_q, mute_d;
   logic                ovr_q, ovr_d;
   logic                clip_q, clip_d;
   aura_snap_t          snap_q, snap_d;
   logic [GAIN_W-1:0]   g_opm_q, g_opm_d;
   logic [GAIN_W-1:0]   g_va_q, g_va_d;
   logic [GAIN_W-1:0]   g_mst_q, g_mst_d;
   logic                mute_s_q, mute_s_d;
   logic [25:0]         acc_q, acc_d;
   logic [SAMPLE_W-1:0] left_q, left_d;
   logic [SAMPLE_W-1:0] l_chan_q, l_chan_d;
   logic [SAMPLE_W-1:0] r_chan_q, r_chan_d;
   logic                out_valid_q, out_valid_d;

   logic signed [15:0]  mul_a;
   logic [GAIN_W-1:0]   mul_b;
   logic signed [24:0]  prod;
   logic [SAMPLE_W-1:0] acc_sat, res_sat;
   logic                acc_clip, res_clip;
   logic                ovr_set, clip_set;

   // Operand select for the shared multiplier; the scale states reuse it for the master gain.
   always_comb begin
      mul_a = '0;
      mul_b = '0;
      case (state_q)
         S_ML0:        begin mul_a = $signed(snap_q.opm_l); mul_b = g_opm_q; end
         S_ML1:        begin mul_a = $signed(snap_q.va_l);  mul_b = g_va_q;  end
         S_MR0:        begin mul_a = $signed(snap_q.opm_r); mul_b = g_opm_q; end
         S_MR1:        begin mul_a = $signed(snap_q.va_r);  mul_b = g_va_q;  end
         S_MSL, S_MSR: begin mul_a = $signed(acc_sat);      mul_b = g_mst_q; end
         default:      begin mul_a = '0;                    mul_b = '0;      end
      endcase
   end

   assign prod = mul_a * $signed({1'b0, mul_b});

   aura_sat16 #(.IN_W(26), .SHIFT(GAIN_FRAC)) u_sat_acc (
      .din_i (acc_q),
      .dout_o(acc_sat),
      .clip_o(acc_clip)
   );

   aura_sat16 #(.IN_W(25), .SHIFT(GAIN_FRAC)) u_sat_mst (
      .din_i (prod),
      .dout_o(res_sat),
      .clip_o(res_clip)
   );

   assign ovr_set  = sample_tick && (state_q != S_IDLE);
   assign clip_set = ((state_q == S_MSL) || (state_q == S_MSR)) && !mute_s_q
                     && (acc_clip || res_clip);

   always_comb begin
      state_d     = state_q;
      opm_gain_d  = opm_gain_q;
      va_gain_d   = va_gain_q;
      mst_gain_d  = mst_gain_q;
      mute_d      = mute_q;
      ovr_d       = ovr_q;
      clip_d      = clip_q;
      snap_d      = snap_q;
      g_opm_d     = g_opm_q;
      g_va_d      = g_va_q;
      g_mst_d     = g_mst_q;
      mute_s_d    = mute_s_q;
      acc_d       = acc_q;
      left_d      = left_q;
      l_chan_d    = l_chan_q;
      r_chan_d    = r_chan_q;
      out_valid_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (sample_tick) begin
               snap_d   = '{opm_l: opm_l_i, opm_r: opm_r_i, va_l: va_l_i, va_r: va_r_i};
               g_opm_d  = opm_gain_q;
               g_va_d   = va_gain_q;
               g_mst_d  = mst_gain_q;
               mute_s_d = mute_q;
               state_d  = S_ML0;
            end
         end
         S_ML0: begin acc_d = {prod[24], prod};          state_d = S_ML1; end
         S_ML1: begin acc_d = acc_q + {prod[24], prod};  state_d = S_MSL; end
         S_MSL: begin
            left_d  = mute_s_q ? '0 : res_sat;
            state_d = S_MR0;
         end
         S_MR0: begin acc_d = {prod[24], prod};          state_d = S_MR1; end
         S_MR1: begin acc_d = acc_q + {prod[24], prod};  state_d = S_MSR; end
         S_MSR: begin
            // Both channels become visible together, left from its holding register.
            l_chan_d    = left_q;
            r_chan_d    = mute_s_q ? '0 : res_sat;
            out_valid_d = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (reg_wr) begin
         case (reg_addr)
            AURA_MIX_OPM_GAIN: opm_gain_d = reg_wdata;
            AURA_MIX_VA_GAIN:  va_gain_d  = reg_wdata;
            AURA_MIX_MST_GAIN: mst_gain_d = reg_wdata;
            default: begin
               mute_d = reg_wdata[CTRL_MUTE_BIT];
               if (reg_wdata[CTRL_OVR_BIT])  ovr_d  = 1'b0;
               if (reg_wdata[CTRL_CLIP_BIT]) clip_d = 1'b0;
            end
         endcase
      end

      // A set event in the same cycle as a write-1-clear keeps the flag set.
      if (ovr_set)  ovr_d  = 1'b1;
      if (clip_set) clip_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         opm_gain_q  <= OPM_GAIN_RST;
         va_gain_q   <= VA_GAIN_RST;
         mst_gain_q  <= MST_GAIN_RST;
         mute_q      <= 1'b0;
         ovr_q       <= 1'b0;
         clip_q      <= 1'b0;
         snap_q      <= '0;
         g_opm_q     <= '0;
         g_va_q      <= '0;
         g_mst_q     <= '0;
         mute_s_q    <= 1'b0;
         acc_q       <= '0;
         left_q      <= '0;
         l_chan_q    <= '0;
         r_chan_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         opm_gain_q  <= opm_gain_d;
         va_gain_q   <= va_gain_d;
         mst_gain_q  <= mst_gain_d;
         mute_q      <= mute_d;
         ovr_q       <= ovr_d;
         clip_q      <= clip_d;
         snap_q      <= snap_d;
         g_opm_q     <= g_opm_d;
         g_va_q      <= g_va_d;
         g_mst_q     <= g_mst_d;
         mute_s_q    <= mute_s_d;
         acc_q       <= acc_d;
         left_q      <= left_d;
         l_chan_q    <= l_chan_d;
         r_chan_q    <= r_chan_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      reg_rdata = '0;
      case (reg_addr)
         AURA_MIX_OPM_GAIN: reg_rdata = opm_gain_q;
         AURA_MIX_VA_GAIN:  reg_rdata = va_gain_q;
         AURA_MIX_MST_GAIN: reg_rdata = mst_gain_q;
         default: begin
            reg_rdata[CTRL_MUTE_BIT] = mute_q;
            reg_rdata[CTRL_OVR_BIT]  = ovr_q;
            reg_rdata[CTRL_CLIP_BIT] = clip_q;
         end
      endcase
   end

   assign l_chan_o  = l_chan_q;
   assign r_chan_o  = r_chan_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_aura_mixer.sv
// Scoreboard bench for aura_mixer: the driver pushes expected samples from an
// integer reference model, a separate monitor pops and compares on out_valid.
module tb_aura_mixer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sample_tick = 1'b0;
   logic [15:0] opm_l_i = '0, opm_r_i = '0, va_l_i = '0, va_r_i = '0;
   logic        reg_wr = 1'b0;
   logic [1:0]  reg_addr = '0;
   logic [7:0]  reg_wdata = '0;
   logic [7:0]  reg_rdata;
   logic [15:0] l_chan_o, r_chan_o;
   logic        out_valid;

   aura_mixer dut (
      .clk        (clk),
      .rst        (rst),
      .sample_tick(sample_tick),
      .opm_l_i    (opm_l_i),
      .opm_r_i    (opm_r_i),
      .va_l_i     (va_l_i),
      .va_r_i     (va_r_i),
      .reg_wr     (reg_wr),
      .reg_addr   (reg_addr),
      .reg_wdata  (reg_wdata),
      .reg_rdata  (reg_rdata),
      .l_chan_o   (l_chan_o),
      .r_chan_o   (r_chan_o),
      .out_valid  (out_valid)
   );

   always #20 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] l;
      logic [15:0] r;
      int          tcyc;
   } exp_t;
   exp_t sb_q[$];

   // Reference model state
   int m_opm, m_va, m_mst;
   bit m_mute, m_ovr, m_clip;
   int busy_until;
   logic [15:0] s_opm_l, s_opm_r, s_va_l, s_va_r;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int sat16(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic void ref_chan(input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] y, output bit c);
      int sum, s, t;
      sum = int'($signed(a)) * m_opm + int'($signed(b)) * m_va;
      s = sum >>> 7;
      c = (sat16(s) != s);
      s = sat16(s);
      t = (s * m_mst) >>> 7;
      if (sat16(t) != t) c = 1'b1;
      y = 16'(sat16(t));
   endfunction

   function automatic void model_reset();
      m_opm = 8'h40; m_va = 8'h40; m_mst = 8'h80;
      m_mute = 0; m_ovr = 0; m_clip = 0;
   endfunction

   // One bus cycle: optional tick (using s_* inputs) and optional register write.
   task automatic drive(input bit tick, input bit wr, input logic [1:0] addr, input logic [7:0] wdata);
      exp_t e;
      bit ovr_ev, pend_clip, cl, cr;
      @(negedge clk);
      // Clearing CLIP while a sample is still in flight would race its later set.
      if (wr && addr == 2'd3 && cyc <= busy_until) wdata[7] = 1'b0;
      rst = 1'b0; sample_tick = tick; reg_wr = wr; reg_addr = addr; reg_wdata = wdata;
      if (tick) begin
         opm_l_i = s_opm_l; opm_r_i = s_opm_r; va_l_i = s_va_l; va_r_i = s_va_r;
      end else begin
         opm_l_i = 16'($urandom); opm_r_i = 16'($urandom);
         va_l_i  = 16'($urandom); va_r_i  = 16'($urandom);
      end
      ovr_ev = 0; pend_clip = 0;
      if (tick) begin
         if (cyc <= busy_until) ovr_ev = 1;
         else begin
            ref_chan(s_opm_l, s_va_l, e.l, cl);
            ref_chan(s_opm_r, s_va_r, e.r, cr);
            if (m_mute) begin e.l = '0; e.r = '0; end
            else pend_clip = cl | cr;
            e.tcyc = cyc;
            sb_q.push_back(e);
            busy_until = cyc + 6;
         end
      end
      if (wr) begin
         case (addr)
            2'd0: m_opm = int'(wdata);
            2'd1: m_va  = int'(wdata);
            2'd2: m_mst = int'(wdata);
            default: begin
               m_mute = wdata[0];
               if (wdata[6]) m_ovr = 0;
               if (wdata[7]) m_clip = 0;
            end
         endcase
      end
      if (ovr_ev) m_ovr = 1;
      if (pend_clip) m_clip = 1;
   endtask

   task automatic idle();
      drive(0, 0, 2'd0, 8'h00);
   endtask

   task automatic wr_reg(input logic [1:0] addr, input logic [7:0] d);
      drive(0, 1, addr, d);
   endtask

   task automatic tick4(input logic [15:0] ol, input logic [15:0] vl, input logic [15:0] orr, input logic [15:0] vr);
      s_opm_l = ol; s_va_l = vl; s_opm_r = orr; s_va_r = vr;
      drive(1, 0, 2'd0, 8'h00);
   endtask

   task automatic read_check(input string name, input logic [1:0] addr);
      logic [7:0] exp;
      while (cyc + 1 <= busy_until) idle();
      drive(0, 0, addr, 8'h00);
      case (addr)
         2'd0:    exp = 8'(m_opm);
         2'd1:    exp = 8'(m_va);
         2'd2:    exp = 8'(m_mst);
         default: exp = {m_clip, m_ovr, 5'b0, m_mute};
      endcase
      #1;
      check(name, 32'(reg_rdata), 32'(exp));
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (sb_q.size() != 0 && n < 40) begin idle(); n++; end
      if (sb_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL %s: %0d samples still pending, required 0", name, sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; sample_tick = 1'b0; reg_wr = 1'b0;
      sb_q.delete();
      model_reset();
      busy_until = cyc;
   endtask

   // Monitor
   logic [15:0] hold_l = '0, hold_r = '0;
   exp_t mon_e;
   always @(posedge clk) begin
      #1;
      if (rst) begin
         hold_l = '0; hold_r = '0;
      end else if (out_valid) begin
         if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_valid: got out_valid=1 at cycle %0d, required 0", cyc);
         end else begin
            mon_e = sb_q.pop_front();
            check("l_chan", 32'(l_chan_o), 32'(mon_e.l));
            check("r_chan", 32'(r_chan_o), 32'(mon_e.r));
            check("latency", 32'(cyc - mon_e.tcyc), 32'(7));
            $display("txn cyc=%0d l=%h r=%h exp_l=%h exp_r=%h", cyc, l_chan_o, r_chan_o, mon_e.l, mon_e.r);
         end
         hold_l = l_chan_o; hold_r = r_chan_o;
      end else begin
         check("hold_l", 32'(l_chan_o), 32'(hold_l));
         check("hold_r", 32'(r_chan_o), 32'(hold_r));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      logic [7:0] wd;
      model_reset();
      busy_until = -1;
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(out_valid), 32'(0));
      check("rst_l", 32'(l_chan_o), 32'(0));
      check("rst_r", 32'(r_chan_o), 32'(0));
      read_check("rst_opm", 2'd0);
      read_check("rst_va", 2'd1);
      read_check("rst_mst", 2'd2);
      read_check("rst_ctrl", 2'd3);

      // Default gains
      tick4(16'd1000, 16'd2000, 16'(-1000), 16'd0);
      wait_drain("t1_drain");
      check("t1_l", 32'(l_chan_o), 32'(16'd1500));
      check("t1_r", 32'(r_chan_o), 32'(16'hFE0C));
      read_check("t1_ctrl", 2'd3);

      // Unity pass-through of OPM
      wr_reg(2'd0, 8'h80); wr_reg(2'd1, 8'h00); wr_reg(2'd2, 8'h80);
      tick4(16'h1234, 16'h5555, 16'hEDCC, 16'hAAAA);
      wait_drain("t2_drain");
      check("t2_l", 32'(l_chan_o), 32'(16'h1234));
      check("t2_r", 32'(r_chan_o), 32'(16'hEDCC));

      // Saturation both directions
      wr_reg(2'd0, 8'hFF); wr_reg(2'd1, 8'hFF); wr_reg(2'd2, 8'hFF);
      tick4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
      wait_drain("t3a_drain");
      check("t3_lpos", 32'(l_chan_o), 32'(16'h7FFF));
      check("t3_rpos", 32'(r_chan_o), 32'(16'h7FFF));
      read_check("t3_clip", 2'd3);
      tick4(16'h8000, 16'h8000, 16'h8000, 16'h8000);
      wait_drain("t3b_drain");
      check("t3_lneg", 32'(l_chan_o), 32'(16'h8000));
      check("t3_rneg", 32'(r_chan_o), 32'(16'h8000));
      wr_reg(2'd3, 8'h80);
      read_check("t3_clip_clr", 2'd3);

      // Overrun, then W1C colliding with a new overrun
      wr_reg(2'd0, 8'h40); wr_reg(2'd1, 8'h40); wr_reg(2'd2, 8'h80);
      tick4(16'd300, 16'd500, 16'd700, 16'd900);
      idle(); idle();
      tick4(16'd1, 16'd2, 16'd3, 16'd4);
      wait_drain("t4_drain");
      read_check("t4_ovr", 2'd3);
      tick4(16'd100, 16'd200, 16'd300, 16'd400);
      idle();
      s_opm_l = 16'd9; s_va_l = 16'd9; s_opm_r = 16'd9; s_va_r = 16'd9;
      drive(1, 1, 2'd3, 8'h40);
      wait_drain("t4b_drain");
      read_check("t4_ovr_keep", 2'd3);
      wr_reg(2'd3, 8'h40);
      read_check("t4_ovr_clr", 2'd3);

      // Mute, then gain write mid-computation
      wr_reg(2'd3, 8'h01);
      tick4(16'd4000, 16'd3000, 16'd2000, 16'd1000);
      wait_drain("t5_drain");
      check("t5_mute_l", 32'(l_chan_o), 32'(0));
      check("t5_mute_r", 32'(r_chan_o), 32'(0));
      read_check("t5_ctrl", 2'd3);
      wr_reg(2'd3, 8'h00);
      tick4(16'd4000, 16'd3000, 16'd2000, 16'd1000);
      idle();
      wr_reg(2'd2, 8'h40);
      wait_drain("t5b_drain");
      tick4(16'd4000, 16'd3000, 16'd2000, 16'd1000);
      wait_drain("t5c_drain");

      // Reset during a computation
      wr_reg(2'd0, 8'h77);
      tick4(16'd1234, 16'd4321, 16'd1111, 16'd2222);
      idle(); idle(); idle();
      do_reset();
      idle(); idle(); idle(); idle(); idle(); idle(); idle(); idle();
      check("t6_l", 32'(l_chan_o), 32'(0));
      check("t6_r", 32'(r_chan_o), 32'(0));
      read_check("t6_opm", 2'd0);
      read_check("t6_mst", 2'd2);
      read_check("t6_ctrl", 2'd3);
      tick4(16'd1000, 16'd2000, 16'(-1000), 16'd0);
      wait_drain("t6_drain");

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 30) begin
            s_opm_l = 16'($urandom); s_opm_r = 16'($urandom);
            s_va_l = 16'($urandom); s_va_r = 16'($urandom);
            drive(1, ($urandom_range(0, 9) == 0), 2'($urandom_range(0, 2)), 8'($urandom));
         end else if (r < 42) begin
            wr_reg(2'($urandom_range(0, 2)), 8'($urandom));
         end else if (r < 47) begin
            wd = 8'($urandom) & 8'hC1;
            wr_reg(2'd3, wd);
         end else if (r < 55) begin
            read_check("rnd_reg", 2'($urandom_range(0, 3)));
         end else begin
            idle();
         end
      end
      wait_drain("rnd_drain");
      read_check("end_ctrl", 2'd3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
